// File: rtl/pdm_cic_decim_pkg.sv
// Shared sonar constants for the PDM-to-PCM decimator, plus the PCM saturation helper.
package pdm_cic_decim_pkg;

    localparam int CIC_ORDER        = 3;
    localparam int PCM_W            = 16;
    localparam int DEC_LOG2_DEFAULT = 5;

    localparam int PCM_MAX = (1 << (PCM_W - 1)) - 1;
    localparam int PCM_MIN = -(1 << (PCM_W - 1));

    typedef logic signed [PCM_W-1:0] pcm_t;

    function automatic pcm_t sat_pcm(input logic signed [31:0] v);
        if (v > PCM_MAX) return pcm_t'(PCM_MAX);
        if (v < PCM_MIN) return pcm_t'(PCM_MIN);
        return pcm_t'(v);
    endfunction

endpackage

// File: rtl/pdm_cic_decim_if.sv
// Control and PCM output bundle of the decimator; master drives the controls, slave is the filter.
interface pdm_cic_decim_if;
    import pdm_cic_decim_pkg::*;

    logic ce_pdm;
    logic pdm_data_i;
    logic mclear;
    logic en_i;
    pcm_t pcm_o;
    logic pcm_valid_o;

    modport master (
        output ce_pdm, pdm_data_i, mclear, en_i,
        input  pcm_o, pcm_valid_o
    );

    modport slave (
        input  ce_pdm, pdm_data_i, mclear, en_i,
        output pcm_o, pcm_valid_o
    );

endinterface

// File: rtl/pdm_cic_decim_sync.sv
// Two-flop synchronizer bringing the asynchronous PDM pad bit into the wb_clk_i domain.
module pdm_sync (
    input  logic wb_clk_i,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d_i};
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pdm_cic_decim.sv
// Third-order CIC decimator turning a 1-bit PDM stream into 16-bit signed PCM.
// Integrators run at the ce_pdm rate; combs and output scaling run one clock apart after each window.
module pdm_cic_decim
    import pdm_cic_decim_pkg::*;
#(
    parameter int DEC_LOG2 = DEC_LOG2_DEFAULT
) (
    input  logic            wb_clk_i,
    input  logic            rst,
    pdm_cic_decim_if.slave  bus
);

    localparam int W     = 2 + CIC_ORDER * DEC_LOG2;
    localparam int SHIFT = (PCM_W - 1) - CIC_ORDER * DEC_LOG2;
    localparam logic [DEC_LOG2-1:0] PH_LAST = '1;

    typedef logic signed [W-1:0] acc_t;

    logic                pdm_bit;
    logic signed [1:0]   pdm_s2;
    acc_t                pdm_x;
    logic                upd;
    logic                dec_evt;
    acc_t                comb_acc;

    acc_t                integ_q    [CIC_ORDER];
    acc_t                integ_d    [CIC_ORDER];
    acc_t                comb_dly_q [CIC_ORDER];
    acc_t                comb_dly_d [CIC_ORDER];
    logic [DEC_LOG2-1:0] phase_q,    phase_d;
    acc_t                sample_q,   sample_d;
    logic                samp_vld_q, samp_vld_d;
    acc_t                comb3_q,    comb3_d;
    logic                comb_vld_q, comb_vld_d;
    pcm_t                pcm_q,      pcm_d;
    logic                pcm_vld_q,  pcm_vld_d;

    pdm_sync u_sync (
        .wb_clk_i (wb_clk_i),
        .rst      (rst),
        .d_i      (bus.pdm_data_i),
        .q_o      (pdm_bit)
    );

    // 1 -> +1 (2'b01), 0 -> -1 (2'b11), then sign-extended to the accumulator width.
    assign pdm_s2  = {~pdm_bit, 1'b1};
    assign pdm_x   = acc_t'(pdm_s2);
    assign upd     = bus.ce_pdm && bus.en_i;
    assign dec_evt = upd && (phase_q == PH_LAST);

    // NOTE: every variable gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        integ_d    = integ_q;
        comb_dly_d = comb_dly_q;
        phase_d    = phase_q;
        sample_d   = sample_q;
        samp_vld_d = 1'b0;
        comb3_d    = comb3_q;
        comb_vld_d = 1'b0;
        pcm_d      = pcm_q;
        pcm_vld_d  = 1'b0;
        comb_acc   = sample_q;

        if (upd) begin
            integ_d[0] = integ_q[0] + pdm_x;
            for (int k = 1; k < CIC_ORDER; k++) begin
                integ_d[k] = integ_q[k] + integ_d[k-1];
            end
            phase_d = phase_q + 1'b1;
        end

        // The captured sample includes the update made on the event cycle itself.
        if (dec_evt) begin
            sample_d   = integ_d[CIC_ORDER-1];
            samp_vld_d = 1'b1;
        end

        if (samp_vld_q) begin
            for (int k = 0; k < CIC_ORDER; k++) begin
                comb_dly_d[k] = comb_acc;
                comb_acc      = comb_acc - comb_dly_q[k];
            end
            comb3_d    = comb_acc;
            comb_vld_d = 1'b1;
        end

        if (comb_vld_q) begin
            pcm_d     = sat_pcm(32'(comb3_q) <<< SHIFT);
            pcm_vld_d = 1'b1;
        end

        // Clear wins over a simultaneous update and drops any sample in flight.
        if (bus.mclear) begin
            for (int k = 0; k < CIC_ORDER; k++) begin
                integ_d[k]    = '0;
                comb_dly_d[k] = '0;
            end
            phase_d    = '0;
            sample_d   = '0;
            samp_vld_d = 1'b0;
            comb3_d    = '0;
            comb_vld_d = 1'b0;
            pcm_d      = '0;
            pcm_vld_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            // NOTE: the integrator and comb arrays are only a few registers, so they are reset like any other flop.
            integ_q    <= '{default: '0};
            comb_dly_q <= '{default: '0};
            phase_q    <= '0;
            sample_q   <= '0;
            samp_vld_q <= 1'b0;
            comb3_q    <= '0;
            comb_vld_q <= 1'b0;
            pcm_q      <= '0;
            pcm_vld_q  <= 1'b0;
        end else begin
            integ_q    <= integ_d;
            comb_dly_q <= comb_dly_d;
            phase_q    <= phase_d;
            sample_q   <= sample_d;
            samp_vld_q <= samp_vld_d;
            comb3_q    <= comb3_d;
            comb_vld_q <= comb_vld_d;
            pcm_q      <= pcm_d;
            pcm_vld_q  <= pcm_vld_d;
        end
    end

    assign bus.pcm_o       = pcm_q;
    assign bus.pcm_valid_o = pcm_vld_q;

endmodule

// File: doc/pdm_cic_decim.md
PDM_CIC_DECIM -- requirements
Module: pdm_cic_decim

Interface
REQ-001 SHALL have parameter DEC_LOG2, default 5, log2 of the decimation ratio R; legal range 3..5.
REQ-002 SHALL have port wb_clk_i, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset, clocked by wb_clk_i.
REQ-004 SHALL have port ce_pdm, input, 1 bit: one-cycle clock enable, one pulse per microphone clock period.
REQ-005 SHALL have port pdm_data_i, input, 1 bit: raw PDM bit from the pad, asynchronous to wb_clk_i.
REQ-006 SHALL have port mclear, input, 1 bit: synchronous clear of all datapath state.
REQ-007 SHALL have port en_i, input, 1 bit: filter run enable.
REQ-008 SHALL have port pcm_o, output, 16 bits: signed PCM sample, held between updates.
REQ-009 SHALL have port pcm_valid_o, output, 1 bit: one-cycle strobe marking a new pcm_o.

Function
REQ-010 SHALL pass pdm_data_i through a 2-flop synchronizer; only the synchronized bit feeds the filter.
REQ-011 SHALL map the synchronized bit to a 2-bit signed input: 1 -> +1, 0 -> -1.
REQ-012 SHALL implement a 3rd-order CIC decimator with differential delay 1 and ratio R = 2^DEC_LOG2.
REQ-013 SHALL size integrator and comb registers W = 2 + 3*DEC_LOG2 bits, two's complement, wrapping modulo 2^W with no saturation.
REQ-014 SHALL update the three cascaded integrators once per cycle with ce_pdm=1 and en_i=1; otherwise they hold.
REQ-015 SHALL keep a DEC_LOG2-bit phase counter that increments on each integrator update and wraps R-1 -> 0.
REQ-016 SHALL define a decimation event as an integrator update with phase counter = R-1; on it, capture the last integrator output including that update.
REQ-017 SHALL register the three comb differences on the cycle after the decimation event.
REQ-018 SHALL, on the following cycle, compute sat16(comb3 << (15 - 3*DEC_LOG2)), clamped to [-32768, +32767], register it on pcm_o, and pulse pcm_valid_o.
REQ-019 SHALL therefore assert pcm_valid_o exactly 2 clocks after the decimation-event edge, for exactly 1 cycle.
REQ-020 SHALL hold pcm_o stable between pcm_valid_o pulses.
REQ-021 SHALL, on mclear=1, zero the integrators, comb delays, phase counter, pcm_o, and the pipeline valid flags in the same edge; mclear overrides ce_pdm, so any in-flight sample is discarded and no pcm_valid_o is produced for it.
REQ-022 SHALL, when en_i=0, freeze the integrators and phase counter, and still complete any sample already in the comb pipeline.
REQ-023 SHALL treat outputs from the first 3 decimation windows after reset or mclear as settling values; from the 4th onward, pcm_o reflects steady-state input.

Reset
REQ-024 SHALL, on rst=1, set pcm_o=0, pcm_valid_o=0, all integrators, comb delays and the phase counter to 0, and both synchronizer flops to 0.
REQ-025 SHALL let rst take priority over mclear, en_i and ce_pdm, and SHALL let rst asserted mid-window discard the partial window.

Structure
REQ-026 SHALL take CIC_ORDER=3, PCM_W=16 and DEC_LOG2_DEFAULT=5 from the shared sonar package.
REQ-027 SHALL instantiate one sub-module, pdm_sync (2-flop synchronizer, reset to 0).
REQ-028 SHALL use a single clock domain (wb_clk_i) with no negedge logic.

Verification
REQ-029 SHALL cover: DEC_LOG2=5, ce_pdm every 5 clocks, pdm=constant 1 -> from the 4th valid onward pcm_o=+32767 (saturated from +32768); valid pulses exactly 160 clocks apart.
REQ-030 SHALL cover: pdm=constant 0 -> from the 4th valid onward pcm_o=-32768.
REQ-031 SHALL cover: pdm alternating 1,0 per ce_pdm -> from the 4th valid onward pcm_o=0.
REQ-032 SHALL cover: mclear pulsed at ce_pdm #17 of a window -> pcm_o=0 the next cycle, no valid for that window, and the next valid 2 clocks after the 32nd subsequent ce_pdm.
REQ-033 SHALL cover: en_i low for 40 clocks mid-window with pdm=1 -> valid timing shifts by exactly 40 clocks, and steady-state pcm_o stays +32767.
REQ-034 SHALL cover: rst asserted for 1 cycle mid-window, and rst asserted in the cycle between a decimation event and its valid -> pcm_o=0, pcm_valid_o=0, and no stale pulse.
